// File: rtl/alu_pkg.sv
// Shared constants for the TP1 ALU: opcode width and MIPS-style funct codes.
package alu_pkg;

    localparam int unsigned OP_W = 6;

    localparam logic [OP_W-1:0] OP_ADD = 6'b100000;
    localparam logic [OP_W-1:0] OP_SUB = 6'b100010;
    localparam logic [OP_W-1:0] OP_AND = 6'b100100;
    localparam logic [OP_W-1:0] OP_OR  = 6'b100101;
    localparam logic [OP_W-1:0] OP_XOR = 6'b100110;
    localparam logic [OP_W-1:0] OP_NOR = 6'b100111;
    localparam logic [OP_W-1:0] OP_SRA = 6'b000011;
    localparam logic [OP_W-1:0] OP_SRL = 6'b000010;

endpackage

// File: rtl/alu_comb.sv
// Purely combinational ALU datapath selected by a funct code.
module alu_comb
    import alu_pkg::*;
#(
    parameter int unsigned ND_DATA = 4,
    parameter int unsigned NB_OP   = 6
) (
    input  logic [ND_DATA-1:0] a,
    input  logic [ND_DATA-1:0] b,
    input  logic [NB_OP-1:0]   op,
    output logic [ND_DATA-1:0] result_c
);

    // Unknown codes resolve to zero so the LEDs never show X.
    always_comb begin
        result_c = '0;
        case (op)
            OP_ADD:  result_c = a + b;
            OP_SUB:  result_c = a - b;
            OP_AND:  result_c = a & b;
            OP_OR:   result_c = a | b;
            OP_XOR:  result_c = a ^ b;
            OP_NOR:  result_c = ~(a | b);
            OP_SRA:  result_c = ND_DATA'($signed(a) >>> b);
            OP_SRL:  result_c = a >> b;
            default: result_c = '0;
        endcase
    end

endmodule

// File: rtl/alu.sv
// Board-level ALU: combinational datapath driving the LEDs, blanked while in reset.
module alu
    import alu_pkg::*;
#(
    parameter int unsigned ND_DATA = 4,
    parameter int unsigned NB_OP   = 6
) (
    input  logic               clk,
    input  logic               i_rst_n,
    input  logic [ND_DATA-1:0] i_datoA,
    input  logic [ND_DATA-1:0] i_datoB,
    input  logic [NB_OP-1:0]   i_operation,
    output logic [ND_DATA-1:0] o_leds
);

    logic               r_en;
    logic [ND_DATA-1:0] result_c;

    alu_comb #(
        .ND_DATA (ND_DATA),
        .NB_OP   (NB_OP)
    ) u_alu_comb (
        .a        (i_datoA),
        .b        (i_datoB),
        .op       (i_operation),
        .result_c (result_c)
    );

    // Enable follows the reset line one edge late.
    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            r_en <= 1'b0;
        end else begin
            r_en <= 1'b1;
        end
    end

    assign o_leds = r_en ? result_c : '0;

endmodule

// File: tb/tb_alu.sv
// Directed bench for alu with an arithmetic reference model checked every cycle.
module tb_alu;

    localparam int unsigned ND_DATA = 4;
    localparam int unsigned NB_OP   = 6;

    logic               clk;
    logic               i_rst_n;
    logic [ND_DATA-1:0] i_datoA;
    logic [ND_DATA-1:0] i_datoB;
    logic [NB_OP-1:0]   i_operation;
    logic [ND_DATA-1:0] o_leds;

    int n_tests;
    int n_fail;
    bit model_en;
    bit started;

    alu #(
        .ND_DATA (ND_DATA),
        .NB_OP   (NB_OP)
    ) dut (
        .clk         (clk),
        .i_rst_n     (i_rst_n),
        .i_datoA     (i_datoA),
        .i_datoB     (i_datoB),
        .i_operation (i_operation),
        .o_leds      (o_leds)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference result from integer arithmetic on 4-bit operands.
    function automatic logic [3:0] model(input int a, input int b, input logic [5:0] op);
        int r;
        int sa;
        r = 0;
        case (op)
            6'b100000: r = (a + b) % 16;
            6'b100010: r = (a - b + 16) % 16;
            6'b100100: r = a & b;
            6'b100101: r = a | b;
            6'b100110: r = a ^ b;
            6'b100111: r = (~(a | b)) & 15;
            6'b000011: begin
                sa = (a >= 8) ? a - 16 : a;
                r  = (sa >>> b) & 15;
            end
            6'b000010: r = a >> b;
            default:   r = 0;
        endcase
        return 4'(r);
    endfunction

    always @(posedge clk) begin
        model_en <= i_rst_n;
        started  <= 1'b1;
    end

    // Every cycle after the first edge, the LEDs must match the model.
    always @(negedge clk) begin
        logic [3:0] exp;
        if (started) begin
            exp = model_en ? model(int'(i_datoA), int'(i_datoB), i_operation) : 4'd0;
            n_tests++;
            if (o_leds !== exp) begin
                n_fail++;
                $display("FAIL cycle_model t=%0t op=%b a=%b b=%b got=%b exp=%b",
                         $time, i_operation, i_datoA, i_datoB, o_leds, exp);
            end
        end
    end

    task automatic check_lit(input string name, input logic [3:0] exp);
        n_tests++;
        if (o_leds !== exp) begin
            n_fail++;
            $display("FAIL %s got=%b exp=%b", name, o_leds, exp);
        end
    endtask

    task automatic apply(input logic [3:0] a, input logic [3:0] b, input logic [5:0] op,
                         input logic [3:0] exp, input string name);
        @(posedge clk);
        #2;
        i_datoA     = a;
        i_datoB     = b;
        i_operation = op;
        #1;
        check_lit(name, exp);
    endtask

    initial begin
        n_tests     = 0;
        n_fail      = 0;
        model_en    = 1'b0;
        started     = 1'b0;
        i_rst_n     = 1'b0;
        i_datoA     = 4'b0011;
        i_datoB     = 4'b0101;
        i_operation = 6'b100000;

        // Reset blanking and release.
        @(posedge clk); #1;
        check_lit("reset_blank", 4'b0000);
        #1 i_rst_n = 1'b1;
        #1 check_lit("pre_enable_edge", 4'b0000);
        @(posedge clk); #1;
        check_lit("release_add", 4'b1000);

        apply(4'b0011, 4'b0101, 6'b100000, 4'b1000, "add");
        apply(4'b0110, 4'b0011, 6'b100010, 4'b0011, "sub");
        apply(4'b1111, 4'b0001, 6'b100000, 4'b0000, "add_wrap");
        apply(4'b0000, 4'b0001, 6'b100010, 4'b1111, "sub_wrap");
        apply(4'b1100, 4'b1010, 6'b100100, 4'b1000, "and");
        apply(4'b1100, 4'b1010, 6'b100101, 4'b1110, "or");
        apply(4'b1100, 4'b1010, 6'b100110, 4'b0110, "xor");
        apply(4'b1100, 4'b1010, 6'b100111, 4'b0001, "nor");
        apply(4'b1100, 4'b0010, 6'b000011, 4'b1111, "sra_neg");
        apply(4'b1100, 4'b0001, 6'b000010, 4'b0110, "srl");
        apply(4'b0100, 4'b0001, 6'b000011, 4'b0010, "sra_pos");
        apply(4'b1100, 4'b0101, 6'b000011, 4'b1111, "sra_over");
        apply(4'b1100, 4'b0101, 6'b000010, 4'b0000, "srl_over");
        apply(4'b0111, 4'b0100, 6'b000011, 4'b0000, "sra_over_pos");
        apply(4'b1010, 4'b0011, 6'b000010, 4'b0001, "srl_edge");
        apply(4'b1011, 4'b0110, 6'b000000, 4'b0000, "illegal_000000");
        apply(4'b1011, 4'b0110, 6'b111111, 4'b0000, "illegal_111111");
        apply(4'b1011, 4'b0110, 6'b100001, 4'b0000, "illegal_100001");

        // Sweep of all legal codes and a few near-miss codes; checked by the cycle model.
        begin
            logic [5:0] ops [12];
            ops = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100110, 6'b100111,
                    6'b000011, 6'b000010, 6'b100011, 6'b000001, 6'b000100, 6'b110000};
            for (int i = 0; i < 12; i++) begin
                for (int j = 0; j < 16; j += 5) begin
                    @(posedge clk); #2;
                    i_operation = ops[i];
                    i_datoA     = 4'(j * 3 + i);
                    i_datoB     = 4'(j + i);
                end
            end
        end

        // Mid-run reset: output holds until the next edge, then blanks, then returns.
        apply(4'b0011, 4'b0101, 6'b100000, 4'b1000, "midrun_add");
        #1 i_rst_n = 1'b0;
        #1 check_lit("midrun_hold", 4'b1000);
        @(posedge clk); #1;
        check_lit("midrun_blank", 4'b0000);
        #1 i_rst_n = 1'b1;
        #1 check_lit("midrun_still_blank", 4'b0000);
        @(posedge clk); #1;
        check_lit("midrun_restore", 4'b1000);

        @(posedge clk);
        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
